// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER IOBUS responders: timer register map, CTRL fields, FSM states.
package otter_io_pkg;

  localparam logic [31:0] IO_BASE_ADDR = 32'h1100_0100;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_LOAD   = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_INT_EN   = 2;
  localparam int CTRL_PRESC_LO = 8;
  localparam int CTRL_PRESC_HI = 15;
  localparam int STATUS_EXPIRED = 0;

  typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_DONE} tmr_state_t;

  typedef struct packed {
    logic [7:0] prescale;
    logic       int_en;
    logic       periodic;
    logic       en;
  } tmr_ctrl_t;

  function automatic tmr_ctrl_t word_to_ctrl(input logic [31:0] w);
    tmr_ctrl_t c;
    c.prescale = w[CTRL_PRESC_HI:CTRL_PRESC_LO];
    c.int_en   = w[CTRL_INT_EN];
    c.periodic = w[CTRL_PERIODIC];
    c.en       = w[CTRL_EN];
    return c;
  endfunction

  function automatic logic [31:0] ctrl_to_word(input tmr_ctrl_t c);
    return {16'h0000, c.prescale, 5'b00000, c.int_en, c.periodic, c.en};
  endfunction

endpackage

// File: rtl/otter_iobus_timer_if.sv
// IOBUS signal bundle between the OTTER memory stage (master) and a memory-mapped responder (slave).
interface otter_iobus_timer_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  modport master (
    output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    input  IOBUS_IN, INTR
  );

  modport slave (
    input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    output IOBUS_IN, INTR
  );
endinterface

// File: rtl/otter_tick_prescaler.sv
// Divide-by-(div+1) tick generator; counter is held at zero while disabled or cleared.
module otter_tick_prescaler (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] presc;

  // >= keeps the divider from running to 255 if div is lowered mid-count
  assign tick = en && (presc >= div);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= 8'd0;
    end else if (!en || clr || tick) begin
      presc <= 8'd0;
    end else begin
      presc <= presc + 8'd1;
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped prescaled down-counter on the OTTER IOBUS with a level interrupt on expiry.
module otter_iobus_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IO_BASE_ADDR,
  parameter int          COUNT_W   = 32
) (
  input  logic               CLK,
  input  logic               RESET_N,
  otter_iobus_timer_if.slave bus
);

  tmr_state_t         state;
  tmr_ctrl_t          ctrl;
  logic [COUNT_W-1:0] load;
  logic [COUNT_W-1:0] count;
  logic               expired;

  logic               sel;
  logic [1:0]         reg_idx;
  logic               wr_ctrl, wr_load, wr_count, wr_status;
  logic               new_en;
  logic               arm;
  logic               tick;
  logic               tick_hit;
  logic [COUNT_W-1:0] wdata;
  logic [31:0]        rdata;
  logic               unused_bits;

  assign sel     = (bus.IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign reg_idx = bus.IOBUS_ADDR[3:2];
  assign wdata   = bus.IOBUS_OUT[COUNT_W-1:0];
  assign new_en  = bus.IOBUS_OUT[CTRL_EN];

  assign wr_ctrl   = sel && bus.IOBUS_WR && (reg_idx == TMR_CTRL);
  assign wr_load   = sel && bus.IOBUS_WR && (reg_idx == TMR_LOAD);
  assign wr_count  = sel && bus.IOBUS_WR && (reg_idx == TMR_COUNT);
  assign wr_status = sel && bus.IOBUS_WR && (reg_idx == TMR_STATUS);

  assign arm = wr_ctrl && new_en && (state != TMR_RUN);

  // A software COUNT write owns the counter for that cycle, so the tick is discarded
  assign tick_hit = tick && !wr_count;

  assign unused_bits = ^{bus.IOBUS_ADDR[1:0], bus.IOBUS_OUT};

  otter_tick_prescaler u_presc (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .en      (state == TMR_RUN),
    .clr     (arm || wr_count),
    .div     (ctrl.prescale),
    .tick    (tick)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= TMR_IDLE;
      ctrl    <= '0;
      load    <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= word_to_ctrl(bus.IOBUS_OUT);
      if (wr_load) load <= wdata;
      if (wr_status && bus.IOBUS_OUT[STATUS_EXPIRED]) expired <= 1'b0;

      case (state)
        TMR_IDLE, TMR_DONE: begin
          if (arm) begin
            count <= load;
            state <= TMR_RUN;
          end else if (wr_ctrl) begin
            state <= TMR_IDLE;
          end
        end
        TMR_RUN: begin
          if (wr_ctrl && !new_en) begin
            state <= TMR_IDLE;
          end else if (tick_hit) begin
            if (count != '0) begin
              count <= count - COUNT_W'(1);
            end else begin
              // Placed after the W1C above so a simultaneous expiry wins
              expired <= 1'b1;
              if (ctrl.periodic) count <= load;
              else               state <= TMR_DONE;
            end
          end
        end
        default: state <= TMR_IDLE;
      endcase

      if (wr_count) count <= wdata;
    end
  end

  always_comb begin
    rdata = 32'h0000_0000;
    if (sel) begin
      case (reg_idx)
        TMR_CTRL:   rdata = ctrl_to_word(ctrl);
        TMR_LOAD:   rdata = 32'(load);
        TMR_COUNT:  rdata = 32'(count);
        TMR_STATUS: rdata = {31'h0, expired};
        default:    rdata = 32'h0000_0000;
      endcase
    end
  end

  assign bus.IOBUS_IN = rdata;
  assign bus.INTR     = expired && ctrl.int_en;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Directed bench for otter_iobus_timer: register map, one-shot, periodic, races, async reset.
module tb_otter_iobus_timer;
  import otter_io_pkg::*;

  localparam logic [31:0] A_CTRL   = 32'h1100_0100;
  localparam logic [31:0] A_LOAD   = 32'h1100_0104;
  localparam logic [31:0] A_COUNT  = 32'h1100_0108;
  localparam logic [31:0] A_STATUS = 32'h1100_010C;
  localparam logic [31:0] A_OTHER  = 32'h1100_0200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #50 clk = ~clk;

  otter_iobus_timer_if io();

  otter_iobus_timer dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (io)
  );

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    io.IOBUS_ADDR = a;
    io.IOBUS_OUT  = d;
    io.IOBUS_WR   = 1'b1;
    @(posedge clk);
    #1;
    io.IOBUS_WR  = 1'b0;
    io.IOBUS_OUT = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    io.IOBUS_ADDR = a;
    #1;
    d = io.IOBUS_IN;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d: got %h want %h", i, d, 32'h0); end
    end
    total++;
    if (io.INTR !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b want 0", io.INTR); end
    rd(A_OTHER, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unselected_read: got %h want 0", d); end
    total++;
    if (dut.state !== TMR_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, TMR_IDLE); end
    // unused CTRL bits read back as zero
    wr(A_CTRL, 32'hFFFF_FFF8);
    rd(A_CTRL, d);
    total++;
    if (d !== 32'h0000_FF00) begin bad++; $display("FAIL ctrl_unused_bits: got %h want %h", d, 32'h0000_FF00); end
    wr(A_CTRL, 32'h0);
    wr(32'h1100_0204, 32'h5);
    rd(A_LOAD, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unselected_write: got %h want 0", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h0000_0005);
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL oneshot_arm_count: got %0d want 3", d); end
    total++;
    if (dut.state !== TMR_RUN) begin bad++; $display("FAIL oneshot_run: got %0d want %0d", dut.state, TMR_RUN); end
    repeat (3) @(posedge clk);
    #1;
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd0 || io.INTR !== 1'b0) begin bad++; $display("FAIL oneshot_pre: got count=%0d intr=%b want count=0 intr=0", d, io.INTR); end
    @(posedge clk);
    #1;
    rd(A_STATUS, d);
    total++;
    if (d !== 32'd1 || io.INTR !== 1'b1) begin bad++; $display("FAIL oneshot_expire: got status=%0d intr=%b want status=1 intr=1", d, io.INTR); end
    total++;
    if (dut.state !== TMR_DONE) begin bad++; $display("FAIL oneshot_done: got %0d want %0d", dut.state, TMR_DONE); end
    @(posedge clk);
    #1;
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd0 || io.INTR !== 1'b1) begin bad++; $display("FAIL oneshot_hold: got count=%0d intr=%b want count=0 intr=1", d, io.INTR); end
    wr(A_STATUS, 32'h1);
    total++;
    if (io.INTR !== 1'b0) begin bad++; $display("FAIL oneshot_w1c: got intr=%b want 0", io.INTR); end
    wr(A_CTRL, 32'h0);
    total++;
    if (dut.state !== TMR_IDLE) begin bad++; $display("FAIL oneshot_disable: got %0d want %0d", dut.state, TMR_IDLE); end
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h0000_0307);
    rd(A_CTRL, d);
    total++;
    if (d !== 32'h0000_0307) begin bad++; $display("FAIL periodic_ctrl_rb: got %h want %h", d, 32'h0000_0307); end
    repeat (7) @(posedge clk);
    #1;
    total++;
    if (io.INTR !== 1'b0) begin bad++; $display("FAIL periodic_early1: got intr=%b want 0", io.INTR); end
    @(posedge clk);
    #1;
    rd(A_COUNT, d);
    total++;
    if (io.INTR !== 1'b1 || d !== 32'd1) begin bad++; $display("FAIL periodic_first: got intr=%b count=%0d want intr=1 count=1", io.INTR, d); end
    wr(A_STATUS, 32'h1);
    total++;
    if (io.INTR !== 1'b0) begin bad++; $display("FAIL periodic_w1c: got intr=%b want 0", io.INTR); end
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (io.INTR !== 1'b0) begin bad++; $display("FAIL periodic_early2: got intr=%b want 0", io.INTR); end
    @(posedge clk);
    #1;
    total++;
    if (io.INTR !== 1'b1 || dut.state !== TMR_RUN) begin bad++; $display("FAIL periodic_second: got intr=%b state=%0d want intr=1 state=%0d", io.INTR, dut.state, TMR_RUN); end
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h0000_0005);
    @(posedge clk);
    #1;
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL race_count0: got %0d want 0", d); end
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, d);
    total++;
    if (d !== 32'd1 || io.INTR !== 1'b1) begin bad++; $display("FAIL race_expiry_wins: got status=%0d intr=%b want status=1 intr=1", d, io.INTR); end
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL race_later_clear: got %0d want 0", d); end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_count_write();
    logic [31:0] d;
    wr(A_LOAD, 32'd20);
    wr(A_CTRL, 32'h0000_0005);
    wr(A_COUNT, 32'd10);
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd10) begin bad++; $display("FAIL count_write: got %0d want 10", d); end
    @(posedge clk);
    #1;
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd9) begin bad++; $display("FAIL count_after_write: got %0d want 9", d); end
    wr(A_CTRL, 32'h0);
    @(posedge clk);
    #1;
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd9 || dut.state !== TMR_IDLE) begin bad++; $display("FAIL count_frozen: got count=%0d state=%0d want count=9 state=%0d", d, dut.state, TMR_IDLE); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(A_LOAD, 32'd9);
    wr(A_CTRL, 32'h0000_0007);
    repeat (14) @(posedge clk);
    #1;
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd5 || io.INTR !== 1'b1) begin bad++; $display("FAIL areset_pre: got count=%0d intr=%b want count=5 intr=1", d, io.INTR); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd0 || io.INTR !== 1'b0) begin bad++; $display("FAIL areset_immediate: got count=%0d intr=%b want count=0 intr=0", d, io.INTR); end
    total++;
    if (dut.state !== TMR_IDLE) begin bad++; $display("FAIL areset_state: got %0d want %0d", dut.state, TMR_IDLE); end
    rd(A_CTRL, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL areset_ctrl: got %h want 0", d); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(A_COUNT, d);
    total++;
    if (d !== 32'd0 || dut.state !== TMR_IDLE) begin bad++; $display("FAIL areset_after: got count=%0d state=%0d want count=0 state=%0d", d, dut.state, TMR_IDLE); end
  endtask

  initial begin
    io.IOBUS_ADDR = 32'h0;
    io.IOBUS_OUT  = 32'h0;
    io.IOBUS_WR   = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_w1c_race();
    test_count_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
